cacheline_mem_arbiter: RTL and testbench

- Shares the single 256-bit cacheline memory port between the icache downward-facing port (read-only) and the dcache downward-facing port (read and write-back).
- Sits between both caches' dfp_* ports and the memory/burst adapter.
- Grants one transaction at a time and latches its address and data for the whole transaction.
- Routes the response only to the granted requester; round-robin on contention so neither cache starves.

---
 rtl/cacheline_mem_arbiter_pkg.sv | 23 ++
 rtl/cacheline_mem_arbiter_rr.sv | 21 ++
 rtl/cacheline_mem_arbiter.sv | 139 +++++++++++++
 tb/tb_cacheline_mem_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cacheline_mem_arbiter_pkg.sv
// Shared types for the cacheline memory arbiter: widths, FSM states and the
// latched request record that drives the memory port for a whole transaction.
package cacheline_mem_arbiter_pkg;

    localparam int ARB_ADDR_W = 32;
    localparam int ARB_LINE_W = 256;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_GRANT_I,
        ARB_GRANT_D
    } arb_state_t;

    typedef struct packed {
        logic [ARB_ADDR_W-1:0] addr;
        logic                  write;
        logic [ARB_LINE_W-1:0] wdata;
    } arb_req_t;

    localparam logic LAST_ICACHE = 1'b0;
    localparam logic LAST_DCACHE = 1'b1;

endpackage

// File: rtl/cacheline_mem_arbiter_rr.sv
// Two-way round-robin pick, purely combinational: bit 0 is icache, bit 1 dcache.
// On a tie the side that did not win last time is granted.
module cacheline_mem_arbiter_rr
    import cacheline_mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        unique case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last == LAST_DCACHE) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/cacheline_mem_arbiter.sv
// Shares one cacheline memory port between icache (read) and dcache (read/write-back).
// Memory strobe rises the cycle after a grant; waiting requesters simply stay asserted.
module cacheline_mem_arbiter
    import cacheline_mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = ARB_ADDR_W,
    parameter int LINE_WIDTH = ARB_LINE_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_read,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic [LINE_WIDTH-1:0] mem_rdata,
    input  logic                  mem_resp
);

    arb_state_t            state_q, state_d;
    arb_req_t              req_q, req_d;
    logic                  last_q, last_d;
    logic                  mem_read_q, mem_read_d;
    logic                  mem_write_q, mem_write_d;
    logic [LINE_WIDTH-1:0] i_rdata_q, i_rdata_d;
    logic [LINE_WIDTH-1:0] d_rdata_q, d_rdata_d;
    logic [1:0]            grant;

    cacheline_mem_arbiter_rr u_rr (
        .req   ({d_read | d_write, i_read}),
        .last  (last_q),
        .grant (grant)
    );

    assign mem_addr  = req_q.addr;
    assign mem_wdata = req_q.wdata;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        last_d      = last_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_resp      = 1'b0;
        d_resp      = 1'b0;
        i_rdata     = i_rdata_q;
        d_rdata     = d_rdata_q;

        unique case (state_q)
            ARB_IDLE: begin
                if (grant[0]) begin
                    state_d     = ARB_GRANT_I;
                    req_d.addr  = i_addr;
                    req_d.write = 1'b0;
                    req_d.wdata = '0;
                    last_d      = LAST_ICACHE;
                    mem_read_d  = 1'b1;
                end else if (grant[1]) begin
                    // Read and write together is illegal; the write wins.
                    state_d     = ARB_GRANT_D;
                    req_d.addr  = d_addr;
                    req_d.write = d_write;
                    req_d.wdata = d_wdata;
                    last_d      = LAST_DCACHE;
                    mem_read_d  = ~d_write;
                    mem_write_d = d_write;
                end
            end
            ARB_GRANT_I: begin
                if (mem_resp) begin
                    i_resp      = 1'b1;
                    i_rdata     = mem_rdata;
                    i_rdata_d   = mem_rdata;
                    state_d     = ARB_IDLE;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                end
            end
            ARB_GRANT_D: begin
                if (mem_resp) begin
                    d_resp      = 1'b1;
                    state_d     = ARB_IDLE;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    if (req_q.write) begin
                        d_rdata = '0;
                    end else begin
                        d_rdata   = mem_rdata;
                        d_rdata_d = mem_rdata;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ARB_IDLE;
            req_q       <= '0;
            last_q      <= LAST_DCACHE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            last_q      <= last_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    a_no_idle_resp: assert property (@(posedge clk) disable iff (!rst)
        (state_q == ARB_IDLE) |-> !mem_resp);
    a_d_rw_exclusive: assert property (@(posedge clk) disable iff (!rst)
        !(d_read && d_write));
    a_i_aligned: assert property (@(posedge clk) disable iff (!rst)
        (state_q == ARB_IDLE && i_read) |-> (i_addr[4:0] == 5'd0));
    a_d_aligned: assert property (@(posedge clk) disable iff (!rst)
        (state_q == ARB_IDLE && (d_read || d_write)) |-> (d_addr[4:0] == 5'd0));

endmodule

// File: tb/tb_cacheline_mem_arbiter.sv
// Randomised bench for the cacheline memory arbiter: a memory model, a response
// monitor and a round-robin service-order model built from per-cache request lists.
module tb_cacheline_mem_arbiter;

    localparam int AW = 32;
    localparam int LW = 256;

    logic          clk;
    logic          rst;
    logic [AW-1:0] i_addr, d_addr, mem_addr;
    logic          i_read, d_read, d_write, i_resp, d_resp;
    logic          mem_read, mem_write, mem_resp;
    logic [LW-1:0] i_rdata, d_rdata, d_wdata, mem_wdata, mem_rdata;

    cacheline_mem_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .i_addr    (i_addr),
        .i_read    (i_read),
        .i_rdata   (i_rdata),
        .i_resp    (i_resp),
        .d_addr    (d_addr),
        .d_read    (d_read),
        .d_write   (d_write),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_resp    (d_resp),
        .mem_addr  (mem_addr),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_resp  (mem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic          wr;
        logic [LW-1:0] wdata;
        int            lat;
        bit            is_d;
    } txn_t;

    int            n_cmp = 0;
    int            n_err = 0;
    txn_t          iq[$], dq[$], exp_q[$];
    txn_t          cur;
    bit            mem_busy = 1'b0;
    bit            last_d = 1'b1;
    int            wait_cnt = 0;
    logic [LW-1:0] mem_img [logic [AW-1:0]];
    logic [LW-1:0] i_last = '0, d_last = '0, resp_line = '0;

    task automatic check(string tag, logic [LW-1:0] got, logic [LW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        return 32'($urandom_range(1, 63) << 8);
    endfunction

    function automatic logic [LW-1:0] line_at(logic [AW-1:0] a);
        if (mem_img.exists(a)) return mem_img[a];
        return {8{a ^ 32'h5A5A_C3C3}};
    endfunction

    // Memory model: accepts one strobe at a time, answers after the txn's latency.
    initial begin
        mem_resp  = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                mem_busy = 1'b0;
                mem_resp = 1'b0;
            end else begin
                if (mem_resp) begin
                    check("idle_gap", {mem_read, mem_write}, 0);
                    mem_busy = 1'b0;
                end
                mem_resp  = 1'b0;
                mem_rdata = rand_line();
                if (!mem_busy && (mem_read || mem_write)) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_txn", 1, 0);
                        cur.addr = mem_addr; cur.wr = mem_write; cur.wdata = mem_wdata;
                        cur.lat = 0; cur.is_d = mem_write;
                    end else begin
                        cur = exp_q.pop_front();
                        check("txn_addr", mem_addr, cur.addr);
                        check("txn_op", {mem_read, mem_write}, {!cur.wr, cur.wr});
                        if (cur.wr) check("txn_wdata", mem_wdata, cur.wdata);
                    end
                    mem_busy = 1'b1;
                    wait_cnt = cur.lat;
                end else if (mem_busy) begin
                    check("hold_addr", mem_addr, cur.addr);
                    check("hold_op", {mem_read, mem_write}, {!cur.wr, cur.wr});
                    if (cur.wr) check("hold_wdata", mem_wdata, cur.wdata);
                end
                if (mem_busy) begin
                    if (wait_cnt == 0) begin
                        mem_resp = 1'b1;
                        if (cur.wr) mem_img[cur.addr] = cur.wdata;
                        else mem_rdata = line_at(cur.addr);
                        resp_line = cur.wr ? '0 : mem_rdata;
                    end else begin
                        wait_cnt--;
                    end
                end
            end
        end
    end

    // Response monitor: only the served side sees resp; rdata holds otherwise.
    always @(negedge clk) begin
        if (rst) begin
            if (mem_resp && mem_busy) begin
                check("i_resp", i_resp, !cur.is_d);
                check("d_resp", d_resp, cur.is_d);
                check("i_rdata", i_rdata, cur.is_d ? i_last : resp_line);
                check("d_rdata", d_rdata, cur.is_d ? resp_line : d_last);
                if (!cur.is_d) i_last = resp_line;
                else if (!cur.wr) d_last = resp_line;
            end else begin
                check("no_resp", {i_resp, d_resp}, 0);
                check("i_hold", i_rdata, i_last);
                check("d_hold", d_rdata, d_last);
            end
        end
    end

    task automatic present();
        i_read = (iq.size() > 0);
        if (iq.size() > 0) i_addr = iq[0].addr;
        d_read  = 1'b0;
        d_write = 1'b0;
        if (dq.size() > 0) begin
            d_addr  = dq[0].addr;
            d_wdata = dq[0].wdata;
            d_read  = !dq[0].wr;
            d_write = dq[0].wr;
        end
    endtask

    // Inputs of the side being served are scrambled; the grant must not notice.
    task automatic perturb();
        if (cur.is_d) begin
            d_addr  = rand_addr();
            d_wdata = rand_line();
            {d_read, d_write} = 2'($urandom_range(0, 2));
        end else begin
            i_addr = 32'h0000_5000;
            i_read = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic add_txn(bit is_d, logic [AW-1:0] a, bit wr, int lat);
        txn_t t;
        t.addr = a; t.wr = wr; t.wdata = wr ? rand_line() : '0; t.lat = lat; t.is_d = is_d;
        if (is_d) dq.push_back(t); else iq.push_back(t);
    endtask

    // Both lists are raised together; each cache re-raises its next item right after resp.
    task automatic run_round();
        txn_t ai[$], ad[$];
        bit   pick_d, ld, i_done, d_done;
        ai = iq;
        ad = dq;
        ld = last_d;
        while (ai.size() > 0 || ad.size() > 0) begin
            if (ai.size() > 0 && ad.size() > 0) pick_d = !ld;
            else pick_d = (ad.size() > 0);
            if (pick_d) begin exp_q.push_back(ad[0]); ad.delete(0); end
            else begin exp_q.push_back(ai[0]); ai.delete(0); end
            ld = pick_d;
        end
        last_d = ld;
        present();
        @(negedge clk);
        check("lat_pre", {mem_read, mem_write}, 0);
        @(negedge clk);
        check("lat_post", mem_read | mem_write, 1);
        for (int c = 0; c < 400; c++) begin
            if (c > 0) @(negedge clk);
            i_done = i_resp;
            d_done = d_resp;
            @(posedge clk);
            #2;
            if (i_done && iq.size() > 0) iq.delete(0);
            if (d_done && dq.size() > 0) dq.delete(0);
            if (i_done || d_done) present();
            else if (mem_busy && !mem_resp) perturb();
            if (iq.size() == 0 && dq.size() == 0) break;
        end
        check("round_timeout", iq.size() + dq.size(), 0);
        check("round_unserved", exp_q.size(), 0);
        iq.delete(); dq.delete(); exp_q.delete();
        present();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        last_d = 1'b1;
        i_last = '0;
        d_last = '0;
    endtask

    initial begin
        #200000;
        check("watchdog", 0, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        logic [LW-1:0] dead;
        rst = 1'b0; i_read = 1'b0; i_addr = '0;
        d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mem_read", mem_read, 0);
        check("rst_mem_write", mem_write, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_i_resp", i_resp, 0);
        check("rst_d_resp", d_resp, 0);
        check("rst_i_rdata", i_rdata, 0);
        check("rst_d_rdata", d_rdata, 0);
        @(posedge clk);
        #2 rst = 1'b1;

        dead = {8{32'hDEAD_BEEF}};
        mem_img[32'h1000] = dead;
        add_txn(1'b0, 32'h1000, 1'b0, 5);
        run_round();
        check("lone_i_rdata", i_rdata, dead);

        do_reset();
        add_txn(1'b0, 32'h2000, 1'b0, 2);
        add_txn(1'b1, 32'h4000, 1'b1, 3);
        run_round();

        for (int k = 0; k < 3; k++) begin
            add_txn(1'b0, rand_addr(), 1'b0, $urandom_range(0, 3));
            add_txn(1'b1, rand_addr(), 1'b0, $urandom_range(0, 3));
        end
        run_round();

        add_txn(1'b0, 32'h3000, 1'b0, 6);
        run_round();

        begin
            txn_t t;
            t.addr = 32'h6000; t.wr = 1'b1; t.wdata = rand_line(); t.lat = 20; t.is_d = 1'b1;
            exp_q.push_back(t);
            dq.push_back(t);
            last_d = 1'b1;
            present();
            repeat (2) @(negedge clk);
            check("arst_pre_write", mem_write, 1);
            #2 rst = 1'b0;
            #1;
            check("arst_write_drop", mem_write, 0);
            check("arst_read_low", mem_read, 0);
            check("arst_addr_clr", mem_addr, 0);
            dq.delete();
            exp_q.delete();
            present();
            @(posedge clk);
            #2 rst = 1'b1;
            i_last = '0;
            d_last = '0;
        end
        add_txn(1'b0, 32'h7000, 1'b0, 1);
        add_txn(1'b1, 32'h8000, 1'b0, 1);
        run_round();

        for (int r = 0; r < 40; r++) begin
            int ni, nd;
            ni = $urandom_range(0, 3);
            nd = (ni == 0) ? $urandom_range(1, 3) : $urandom_range(0, 3);
            for (int k = 0; k < ni; k++) add_txn(1'b0, rand_addr(), 1'b0, $urandom_range(0, 4));
            for (int k = 0; k < nd; k++)
                add_txn(1'b1, rand_addr(), 1'($urandom_range(0, 1)), $urandom_range(0, 4));
            run_round();
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
